// File: rtl/nbit_stream_demux.sv
// nbit_stream_demux: 1-to-2 valid/ready stream demultiplexer.
// Each input word goes to channel 0 or 1 according to in_sel. Every channel
// owns a 2-entry FIFO, so a stalled consumer never blocks the other channel.
// Outputs come straight from buffer registers; there is no combinational
// path from in_* to out*. Each channel also counts its delivered words.
module nbit_stream_demux #(
    parameter int N  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  in_data,
    input  logic          in_sel,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  out0_data,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [N-1:0]  out1_data,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [CW-1:0] count0,
    output logic [CW-1:0] count1
);

    // Buffer occupancy doubles as the per-channel state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t          occ   [2];
    logic [N-1:0]  mem   [2][2];
    logic          wptr  [2];
    logic          rptr  [2];
    logic [CW-1:0] cnt   [2];
    logic          ready [2];
    logic          push  [2];
    logic          pop   [2];

    assign ready[0] = out0_ready;
    assign ready[1] = out1_ready;

    // A FULL channel refuses new words even if it pops this cycle.
    assign in_ready = (occ[in_sel] != FULL);

    // Per-channel push/pop strobes for the coming edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        for (int k = 0; k < 2; k++) begin
            push[k] = 1'b0;
            pop[k]  = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            push[k] = in_valid && in_ready && (int'(in_sel) == k);
            pop[k]  = (occ[k] != EMPTY) && ready[k];
        end
    end

    // Buffer storage, pointers, occupancy and delivered-word counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                occ[k]  <= EMPTY;
                wptr[k] <= 1'b0;
                rptr[k] <= 1'b0;
                cnt[k]  <= '0;
                // NOTE: storage is reset because the head entry is a visible output that must read zero out of reset.
                mem[k][0] <= '0;
                mem[k][1] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                // NOTE: non-blocking assignments so every register updates from pre-edge values.
                if (push[k]) begin
                    mem[k][wptr[k]] <= in_data;
                    wptr[k]         <= ~wptr[k];
                end
                if (pop[k]) begin
                    rptr[k] <= ~rptr[k];
                    cnt[k]  <= cnt[k] + 1'b1;
                end
                // Push and pop together in ONE leave the occupancy unchanged.
                unique case ({push[k], pop[k]})
                    2'b10:   occ[k] <= occ_t'(occ[k] + 2'd1);
                    2'b01:   occ[k] <= occ_t'(occ[k] - 2'd1);
                    default: occ[k] <= occ[k];
                endcase
            end
        end
    end

    assign out0_valid = (occ[0] != EMPTY);
    assign out1_valid = (occ[1] != EMPTY);
    assign out0_data  = mem[0][rptr[0]];
    assign out1_data  = mem[1][rptr[1]];
    assign count0     = cnt[0];
    assign count1     = cnt[1];

endmodule

// File: doc/nbit_stream_demux.md
Name: nbit_stream_demux

Overview:
- 1-to-2 demultiplexer for a valid/ready data stream. It is the inverse of the N-bit 2-input mux.
- Each input word is routed to output channel 0 or 1 according to a per-word select bit.
- Each channel has its own 2-entry buffer, so a stalled channel never blocks traffic to the other.
- Sits between a single producer (keypad/timer datapath) and two consumers (e.g. display and control logic).

Parameters:
N, 16, data word width in bits
CW, 8, width of each per-channel delivered-word counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  N  input word
in_sel  input  1  destination for in_data: 0 = channel 0, 1 = channel 1
in_valid  input  1  producer has a word on in_data/in_sel
in_ready  output  1  demux accepts the word this cycle
out0_data  output  N  channel 0 head word
out0_valid  output  1  channel 0 head word valid
out0_ready  input  1  channel 0 consumer accepts head word
out1_data  output  N  channel 1 head word
out1_valid  output  1  channel 1 head word valid
out1_ready  input  1  channel 1 consumer accepts head word
count0  output  CW  words delivered on channel 0, modulo 2^CW
count1  output  CW  words delivered on channel 1, modulo 2^CW

Behaviour:
- Clocking and reset:
  - One clock domain. rst_n is asynchronous and active-low.
  - When rst_n goes low, at any time: both buffers are emptied and both counters clear.
  - Reset values: out0_valid = 0, out1_valid = 0, out0_data = 0, out1_data = 0, count0 = 0, count1 = 0.
  - Words in flight when reset asserts are discarded, with no partial delivery.
- Per-channel buffer:
  - 2-entry FIFO with write pointer, read pointer and 2-bit occupancy (0..2).
  - Buffer states: EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
  - Pointers wrap 1 -> 0.
- Input acceptance:
  - in_ready = NOT full of the channel selected by in_sel. This is combinational from in_sel and registered occupancy.
  - Accept (push) occurs when in_valid & in_ready at a rising edge. in_data is written to the selected channel only.
  - The unselected channel's state is unaffected by the push.
  - If the selected channel is FULL, in_ready = 0 even if that channel pops in the same cycle. No pass-through on full.
- Output:
  - outK_valid = occupancy of channel K is nonzero. outK_data = entry at the read pointer.
  - Both are driven from registers, with no combinational path from in_* to out*.
  - Pop occurs when outK_valid & outK_ready at a rising edge. The read pointer advances and countK increments by 1.
  - countK wraps 2^CW-1 -> 0.
- Latency: a word accepted at edge t is visible on outK at edge t (occ was 0), i.e. valid in cycle t+1. Minimum latency is 1 cycle.
- Simultaneous push and pop on the same channel:
  - Allowed in EMPTY (pop impossible, since valid = 0) and in ONE.
  - In ONE, occupancy stays 1 and head = new word on the next cycle.
- Both channels may pop in the same cycle. Only one push per cycle is possible.
- Ordering: per-channel order is preserved. Cross-channel order is not defined.
- outK_valid, once asserted, stays asserted with stable outK_data until popped or reset.
- Throughput: one word per cycle sustained to a channel whose consumer holds ready high.
- in_valid low: no state change other than pops.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst_n = 0 for 3 cycles mid-stream with 2 words buffered.
  - Required: out0_valid = out1_valid = 0, out0_data = out1_data = 0, count0 = count1 = 0.
  - Required: in_ready = 1 for either in_sel after release.
- Routing:
  - Stimulus: push FFFF (sel 0), then ABCD (sel 1), with both readies high.
  - Required: out0_data = FFFF valid 1 cycle after accept, and out1_data = ABCD likewise.
  - Required: count0 = 1, count1 = 1, and the other channel's valid stays 0.
- Backpressure and full:
  - Stimulus: out0_ready = 0, push 0101, 5985 to sel 0.
  - Required: in_ready = 0 for sel 0, while sel 1 still accepts DCBA with in_ready = 1.
  - Stimulus: raise out0_ready.
  - Required: 0101 then 5985 are delivered in order, and count0 = 2.
- Push/pop same cycle:
  - Stimulus: channel 1 holds 1 word, push 1234 (sel 1) while out1_ready = 1.
  - Required: occupancy stays 1, out1_data = 1234 next cycle, and count1 increments.
- Counter wrap (CW = 8):
  - Stimulus: deliver 256 words on channel 0.
  - Required: count0 returns to 0, and count1 is unchanged.
- Held stability:
  - Stimulus: out1_ready = 0 for 10 cycles with head 00AA.
  - Required: out1_valid = 1 and out1_data = 00AA constant throughout.
